// File: rtl/poly_addsub_ctrl.sv
// Purpose : sequences N coefficient pairs from memories A/B through an external modular adder into a result memory.
// Latency : read of index i issued in cycle k, result for i written in cycle k+2; done_o pulses 3 cycles after the last read.
// Backpr. : none; the memories and the adder are fixed-latency, so the block streams one index per cycle without stalling.
//
// Ports
//   clk_i, rst_ni                  clock (rising edge), async active-low reset
//   start_i, sub_i, modulus_i      start request (taken only in IDLE), add/sub select and q, both latched at start
//   busy_o, done_o                 run in progress (RUN/DRAIN), one-cycle completion pulse
//   rd_en_o, rd_addr_o             read port shared by memories A and B (synchronous read, data next cycle)
//   rd_data_a_i, rd_data_b_i       A[idx], B[idx]
//   add_mod_o, add_in1_o,
//   add_in2_o, add_result_i        combinational modular adder interface
//   wr_en_o, wr_addr_o, wr_data_o  result memory write port
module poly_addsub_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 256,
  parameter int ADDR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  sub_i,
  input  logic [DATA_WIDTH-1:0] modulus_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_a_i,
  input  logic [DATA_WIDTH-1:0] rd_data_b_i,
  output logic [DATA_WIDTH-1:0] add_mod_o,
  output logic [DATA_WIDTH-1:0] add_in1_o,
  output logic [DATA_WIDTH-1:0] add_in2_o,
  input  logic [DATA_WIDTH-1:0] add_result_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);

  // Read counter carries one extra bit so N = 2^ADDR_WIDTH ends without wrapping.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  drain_q, drain_d;
  logic [DATA_WIDTH-1:0] mod_q, mod_d;
  logic                  sub_q, sub_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] neg_b;

  // Control FSM: next state, read port and status outputs.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    drain_d   = drain_q;
    mod_d     = mod_q;
    sub_d     = sub_q;
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mod_d    = modulus_i;
          sub_d    = sub_i;
          rd_cnt_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o    = 1'b1;
        rd_en_o   = 1'b1;
        rd_addr_o = rd_cnt_q[ADDR_WIDTH-1:0];
        rd_cnt_d  = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Two cycles: one for the last read's data/adder stage, one for its write.
        busy_o  = 1'b1;
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand stage: memory data arrives the cycle after the read; q - b negates b,
  // with b == 0 mapped to 0 so the adder never sees q itself as an operand.
  always_comb begin
    neg_b     = (rd_data_b_i == '0) ? '0 : (mod_q - rd_data_b_i);
    add_in1_o = '0;
    add_in2_o = '0;
    if (s1_vld_q) begin
      add_in1_o = rd_data_a_i;
      add_in2_o = sub_q ? neg_b : rd_data_b_i;
    end
    add_mod_o = mod_q;
  end

  // Pipeline: read issue -> operand stage -> write register.
  always_comb begin
    s1_vld_d  = rd_en_o;
    s1_idx_d  = rd_addr_o;
    wr_en_d   = s1_vld_q;
    wr_addr_d = s1_idx_q;
    wr_data_d = s1_vld_q ? add_result_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      drain_q   <= 1'b0;
      mod_q     <= '0;
      sub_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      drain_q   <= drain_d;
      mod_q     <= mod_d;
      sub_q     <= sub_d;
      s1_vld_q  <= s1_vld_d;
      s1_idx_q  <= s1_idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// Purpose : bench for poly_addsub_ctrl with memory/adder environment and a cycle-level reference model.
// Latency : model predicts every output per cycle relative to the accepted start edge.
// Backpr. : none; memories respond in fixed time.
module tb_poly_addsub_ctrl;
  localparam int N  = 256;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, sub;
  logic [DW-1:0] modulus;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_a = '0, rd_b = '0;
  logic [DW-1:0] add_mod, add_in1, add_in2, add_res, wr_data;

  always #5 clk = ~clk;

  poly_addsub_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sub_i(sub), .modulus_i(modulus),
    .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_a_i(rd_a), .rd_data_b_i(rd_b), .add_mod_o(add_mod),
    .add_in1_o(add_in1), .add_in2_o(add_in2), .add_result_i(add_res),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  // Environment: synchronous-read memories and combinational modular adder.
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  logic [DW-1:0] res_mem [N];
  int            wr_seen [N];
  int            wr_total;

  always @(posedge clk) if (rd_en) begin
    rd_a <= mem_a[rd_addr];
    rd_b <= mem_b[rd_addr];
  end

  always_comb begin
    int s;
    s = int'(add_in1) + int'(add_in2);
    add_res = (s >= int'(add_mod)) ? DW'(s - int'(add_mod)) : DW'(s);
  end

  int tests = 0, fails = 0;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_op(int a, int b, int q, bit s);
    int r;
    r = s ? a - b : a + b;
    if (r < 0) r += q;
    if (r >= q) r -= q;
    return r;
  endfunction

  // Reference model: m_cyc is the cycle number of the current run (0 = idle).
  int      cyc = 0, m_cyc = 0, start_edge = 0;
  int      m_q;
  bit      m_sub;
  int      m_exp [N];
  int      busy_cnt, done_cnt = 0, first_wr_rel, done_rel, in2_at2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0;
    end else begin
      cyc++;
      if (m_cyc == 0) begin
        if (start) begin
          m_cyc = 1;
          m_q = int'(modulus);
          m_sub = sub;
          start_edge = cyc;
          busy_cnt = 0;
          first_wr_rel = -1;
          done_rel = -1;
          wr_total = 0;
          for (int i = 0; i < N; i++) begin
            m_exp[i] = ref_op(int'(mem_a[i]), int'(mem_b[i]), m_q, m_sub);
            wr_seen[i] = 0;
          end
        end
      end else if (m_cyc == N + 3) begin
        m_cyc = 0;
      end else begin
        m_cyc++;
      end
    end
  end

  always @(posedge clk) if (rst_n && wr_en) begin
    res_mem[wr_addr] = wr_data;
    wr_seen[wr_addr]++;
    wr_total++;
  end

  // Compare process: every cycle, sampled 1 time unit after the clock edge.
  always @(posedge clk) begin
    int c, i, eb, e2, rel;
    #1;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);   chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_en", wr_en, 0);   chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0); chk("rst_add_mod", add_mod, 0);
      chk("rst_add_in1", add_in1, 0); chk("rst_add_in2", add_in2, 0);
    end else begin
      c = m_cyc;
      rel = cyc - start_edge + 1;
      chk("busy", busy, (c >= 1 && c <= N + 2));
      chk("done", done, (c == N + 3));
      chk("rd_en", rd_en, (c >= 1 && c <= N));
      chk("wr_en", wr_en, (c >= 3 && c <= N + 2));
      if (c >= 1) chk("add_mod", add_mod, m_q);
      if (c >= 1 && c <= N) chk("rd_addr", rd_addr, c - 1);
      if (c >= 2 && c <= N + 1) begin
        i  = c - 2;
        eb = int'(mem_b[i]);
        e2 = m_sub ? ((eb == 0) ? 0 : m_q - eb) : eb;
        chk("add_in1", add_in1, mem_a[i]);
        chk("add_in2", add_in2, e2);
      end
      if (c >= 3 && c <= N + 2) begin
        chk("wr_addr", wr_addr, c - 3);
        chk("wr_data", wr_data, m_exp[c - 3]);
      end
      if (c == 4) in2_at2 = int'(add_in2);
      if (busy) busy_cnt++;
      if (wr_en && first_wr_rel < 0) first_wr_rel = rel;
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
    end
  end

  task automatic fill_rand(int q);
    for (int i = 0; i < N; i++) begin
      mem_a[i] = DW'($urandom_range(q - 1, 0));
      mem_b[i] = DW'($urandom_range(q - 1, 0));
    end
  endtask

  // Drive start for one cycle; returns at the negedge of run cycle 1.
  task automatic kick(int q, bit s);
    start = 1'b1; modulus = DW'(q); sub = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < N + 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, (done_cnt != d0), 1);
    @(negedge clk);
  endtask

  task automatic check_once(string name);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (wr_seen[i] != 1) bad++;
    chk({name, "_idx_once"}, bad, 0);
    chk({name, "_busy_cycles"}, busy_cnt, N + 2);
  endtask

  initial begin
    int q, d0, s0, t0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; modulus = '0;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; res_mem[i] = '0; wr_seen[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: add, q=3329, known vectors at idx 0..3.
    fill_rand(3329);
    mem_a[0] = 16'd1; mem_a[1] = 16'd3328; mem_a[2] = 16'd1664; mem_a[3] = 16'd0;
    mem_b[0] = 16'd2; mem_b[1] = 16'd1;    mem_b[2] = 16'd1665; mem_b[3] = 16'd0;
    kick(3329, 1'b0);
    wait_done("t1");
    chk("t1_r0", res_mem[0], 3);
    chk("t1_r1", res_mem[1], 0);
    chk("t1_r2", res_mem[2], 0);
    chk("t1_r3", res_mem[3], 0);
    chk("t1_first_wr_cycle", first_wr_rel, 3);
    chk("t1_done_cycle", done_rel, N + 3);
    check_once("t1");

    // 2: sub, q=3329, including b == 0.
    fill_rand(3329);
    mem_a[0] = 16'd5; mem_a[1] = 16'd0; mem_a[2] = 16'd7;
    mem_b[0] = 16'd3; mem_b[1] = 16'd1; mem_b[2] = 16'd0;
    kick(3329, 1'b1);
    wait_done("t2");
    chk("t2_r0", res_mem[0], 2);
    chk("t2_r1", res_mem[1], 3328);
    chk("t2_r2", res_mem[2], 7);
    chk("t2_in2_b0", in2_at2, 0);

    // 3: random full runs, add then sub.
    for (int k = 0; k < 2; k++) begin
      q = int'($urandom_range(32767, 2));
      fill_rand(q);
      kick(q, k[0]);
      wait_done("t3");
      check_once("t3");
    end

    // 4: start pulses inside a run and in DONE are ignored; start right after DONE is taken.
    q = 12289;
    fill_rand(q);
    d0 = done_cnt;
    kick(q, 1'b0);
    s0 = start_edge;
    for (int c = 2; c <= N + 4; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 50 || c == N + 3 || c == N + 4);
    end
    @(negedge clk);
    start = 1'b0;
    chk("t4_restart_edge", start_edge - s0, N + 4);
    wait_done("t4");
    chk("t4_done_pulses", done_cnt - d0, 2);

    // 5: reset in cycle 10 of a run.
    q = 7681;
    fill_rand(q);
    d0 = done_cnt;
    kick(q, 1'b1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_now", busy, 0);
    chk("t5_rd_en_now", rd_en, 0);
    chk("t5_wr_en_now", wr_en, 0);
    t0 = wr_total;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 10) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_more_writes", wr_total, t0);
    fill_rand(q);
    kick(q, 1'b0);
    wait_done("t5");
    check_once("t5");

    // 6: modulus/sub changed mid-run must not affect results.
    fill_rand(3329);
    mem_a[100] = 16'd3000; mem_b[100] = 16'd300;
    kick(3329, 1'b0);
    repeat (18) @(negedge clk);
    modulus = 16'd1000; sub = 1'b1;
    wait_done("t6");
    chk("t6_r100", res_mem[100], 3300);
    check_once("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
